// File: rtl/chacha_stream_xor.sv
// Streams 32-bit words XORed with ChaCha keystream blocks produced by an external block core.
// Define CHACHA_CTR_OVF_ERR_EN to add a sticky err output that stops the message on block-counter overflow.
module chacha_stream_xor #(
  parameter int unsigned CORE_WAIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  output logic [511:0] core_state,
  input  logic [511:0] core_ks,
  input  logic [31:0]  din,
  input  logic         din_valid,
  input  logic         din_last,
  output logic         din_ready,
  output logic [31:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic [31:0]  ctr,
`ifdef CHACHA_CTR_OVF_ERR_EN
  output logic         err,
`endif
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(CORE_WAIT);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [255:0]  key_r;
  logic [95:0]   nonce_r;
  logic [511:0]  ks_buf;
  logic [3:0]    idx;
  logic [31:0]   ks_word;
  logic          accept;

  assign core_state = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                       key_r, ctr, nonce_r};

  assign busy      = (state != IDLE);
  assign din_ready = (state == STREAM) && (!dout_valid || dout_ready);
  assign accept    = din_valid && din_ready;

  always_comb begin
    ks_word = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (idx == 4'(i)) ks_word = ks_buf[511 - 32*i -: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      key_r      <= '0;
      nonce_r    <= '0;
      ctr        <= '0;
      ks_buf     <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
`ifdef CHACHA_CTR_OVF_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_r    <= key;
            nonce_r  <= nonce;
            ctr      <= ctr_init;
            wait_cnt <= '0;
            state    <= GEN;
`ifdef CHACHA_CTR_OVF_ERR_EN
            err      <= 1'b0;
`endif
          end
        end
        GEN: begin
          // core_ks is only trusted once the multicycle core path has settled
          if (wait_cnt == WAIT_LAST) begin
            ks_buf <= core_ks;
            idx    <= '0;
            state  <= STREAM;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        STREAM: begin
          if (accept) begin
            dout       <= din ^ ks_word;
            dout_valid <= 1'b1;
            idx        <= idx + 4'd1;
            if (din_last) begin
              state  <= IDLE;
              done   <= 1'b1;
              idx    <= '0;
              ks_buf <= '0;
            end else if (idx == 4'hf) begin
`ifdef CHACHA_CTR_OVF_ERR_EN
              if (ctr == '1) begin
                err    <= 1'b1;
                state  <= IDLE;
                ks_buf <= '0;
              end else begin
                ctr      <= ctr + 32'd1;
                wait_cnt <= '0;
                state    <= GEN;
              end
`else
              ctr      <= ctr + 32'd1;
              wait_cnt <= '0;
              state    <= GEN;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Randomized bench for chacha_stream_xor: a ChaCha20 block model stands in for the core and
// predicts every output word from key, nonce, initial counter and word position.
`timescale 1ns/1ps
module tb_chacha_stream_xor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, din_valid, din_last, dout_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init, din;

  logic [511:0] cs_a, ks_a, cs_b, ks_b, ks_b1, ks_b2;
  logic         rdy_a, dv_a, busy_a, done_a, rdy_b, dv_b, busy_b, done_b;
  logic [31:0]  dout_a, ctr_a, dout_b, ctr_b;
`ifdef CHACHA_CTR_OVF_ERR_EN
  logic         err_a, err_b;
`endif

  logic         sel;
  logic         o_rdy, o_dv, o_busy, o_done;
  logic [31:0]  o_dout, o_ctr;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  first_dout;
  logic [255:0] m_key;
  logic [95:0]  m_nonce;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [511:0] st);
    logic [31:0]  x[16];
    logic [31:0]  s[16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      s[i] = st[511 - 32*i -: 32];
      x[i] = s[i];
    end
    for (int rnd = 0; rnd < 10; rnd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = x[i] + s[i];
    return r;
  endfunction

  // Keystream word j of a message: block ci + j/16, word j%16.
  function automatic logic [31:0] model_ks(input logic [255:0] k, input logic [95:0] n,
                                           input logic [31:0] ci, input int j);
    logic [511:0] blk;
    logic [31:0]  bc;
    bc  = ci + 32'(j / 16);
    blk = chacha_block({32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, k, bc, n});
    return blk[511 - 32*(j % 16) -: 32];
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb ks_a = chacha_block(cs_a);

  always_ff @(posedge clk) begin
    ks_b1 <= chacha_block(cs_b);
    ks_b2 <= ks_b1;
    ks_b  <= ks_b2;
  end

  chacha_stream_xor #(.CORE_WAIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce), .ctr_init(ctr_init),
    .core_state(cs_a), .core_ks(ks_a), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(rdy_a), .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
    .busy(busy_a), .ctr(ctr_a),
`ifdef CHACHA_CTR_OVF_ERR_EN
    .err(err_a),
`endif
    .done(done_a)
  );

  chacha_stream_xor #(.CORE_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce), .ctr_init(ctr_init),
    .core_state(cs_b), .core_ks(ks_b), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(rdy_b), .dout(dout_b), .dout_valid(dv_b), .dout_ready(dout_ready),
    .busy(busy_b), .ctr(ctr_b),
`ifdef CHACHA_CTR_OVF_ERR_EN
    .err(err_b),
`endif
    .done(done_b)
  );

  always_comb begin
    o_rdy  = sel ? rdy_b  : rdy_a;
    o_dv   = sel ? dv_b   : dv_a;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_dout = sel ? dout_b : dout_a;
    o_ctr  = sel ? ctr_b  : ctr_a;
  end

  task automatic run_msg(input int n, input logic [31:0] ci, input bit send_last,
                         input bit zero_din, input int stall_at, input bit poke_start);
    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    int          sent, got, cyc, cw, gap_exp;
    bit          acc_in, acc_out, last_prev, have_snap, poked, stalled;
    logic [31:0] snap, e, ec;
    cw = sel ? 3 : 0;
    m_key = key; m_nonce = nonce;
    @(posedge clk); #1;
    start = 1'b1; ctr_init = ci; din_valid = 1'b1;
    din = zero_din ? 32'h0 : $urandom;
    din_last = send_last && (n == 1);
    dout_ready = 1'b1;
    sent = 0; got = 0; cyc = 0; last_prev = 0; have_snap = 0; poked = 0; snap = '0;
    while (got < n && cyc < 4*n + 60) begin
      @(negedge clk);
      n_cmp++;
      if (o_done !== last_prev) begin
        n_err++; $display("FAIL done cyc=%0d got %b want %b", cyc, o_done, last_prev);
      end
      stalled = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
      if (stalled && o_dv) begin
        n_cmp++;
        if (o_rdy !== 1'b0) begin
          n_err++; $display("FAIL stall_din_ready cyc=%0d got %b want 0", cyc, o_rdy);
        end
        if (!have_snap) begin
          snap = o_dout; have_snap = 1;
        end else begin
          n_cmp++;
          if (o_dout !== snap) begin
            n_err++; $display("FAIL stall_dout cyc=%0d got %h want %h", cyc, o_dout, snap);
          end
        end
      end
      acc_out = o_dv && dout_ready;
      if (acc_out) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL dout_extra cyc=%0d got %h want none", cyc, o_dout);
        end else begin
          e = exp_q.pop_front();
          if (o_dout !== e) begin
            n_err++; $display("FAIL dout word=%0d got %h want %h", got, o_dout, e);
          end
        end
        if (got == 0) first_dout = o_dout;
        got++;
      end
      acc_in = din_valid && o_rdy;
      last_prev = acc_in && din_last;
      if (acc_in) begin
        ec = ci + 32'(sent / 16);
        n_cmp++;
        if (o_ctr !== ec) begin
          n_err++; $display("FAIL ctr word=%0d got %h want %h", sent, o_ctr, ec);
        end
        exp_q.push_back(din ^ model_ks(m_key, m_nonce, ci, sent));
        acc_cyc.push_back(cyc);
        sent++;
      end
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      if (acc_in) begin
        if (sent < n) begin
          din = zero_din ? 32'h0 : $urandom;
          din_last = send_last && (sent == n - 1);
        end else begin
          din_valid = 1'b0; din_last = 1'b0;
        end
      end
      if (poke_start && !poked && sent == 5) begin
        start = 1'b1; key = rand_key(); nonce = {$urandom, $urandom, $urandom};
        ctr_init = $urandom; poked = 1;
      end
      dout_ready = !((stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5));
    end
    din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
    n_cmp++;
    if (got != n || exp_q.size() != 0) begin
      n_err++; $display("FAIL msg_count got %0d want %0d pending %0d", got, n, exp_q.size());
    end
    if (acc_cyc.size() > 0) begin
      n_cmp++;
      if (acc_cyc[0] != cw + 2) begin
        n_err++; $display("FAIL first_accept_cycle got %0d want %0d", acc_cyc[0], cw + 2);
      end
    end
    if (stall_at < 0) begin
      for (int i = 1; i < acc_cyc.size(); i++) begin
        gap_exp = (i % 16 == 0) ? cw + 2 : 1;
        n_cmp++;
        if (acc_cyc[i] - acc_cyc[i-1] != gap_exp) begin
          n_err++;
          $display("FAIL accept_gap word=%0d got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], gap_exp);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL end_state got done=%b busy=%b want 0/0", o_done, o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; din_valid = 0; din_last = 0; dout_ready = 1; sel = 0;
    key = '0; nonce = '0; ctr_init = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_busy, o_rdy, o_dv, o_dout, o_done, o_ctr} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", {o_busy, o_rdy, o_dv, o_dout, o_done, o_ctr});
    end
    n_cmp++;
    if (cs_a !== {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, 384'h0}) begin
      n_err++; $display("FAIL reset_core_state got %h", cs_a);
    end
`ifdef CHACHA_CTR_OVF_ERR_EN
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_err++; $display("FAIL reset_err got %b want 0", err_a);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_rfc_vector();
    key = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
           32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    nonce = {32'h09000000, 32'h4a000000, 32'h00000000};
    run_msg(4, 32'd1, 1, 1, -1, 0);
    n_cmp++;
    if (first_dout !== 32'he4e7f110) begin
      n_err++; $display("FAIL rfc_first_word got %h want e4e7f110", first_dout);
    end
    n_cmp++;
    if (o_ctr !== 32'd1) begin
      n_err++; $display("FAIL rfc_ctr got %h want 00000001", o_ctr);
    end
  endtask

  task automatic test_multi_block();
    key = rand_key(); nonce = {$urandom, $urandom, $urandom};
    run_msg(40, 32'd1, 1, 0, -1, 0);
    n_cmp++;
    if (o_ctr !== 32'd3) begin
      n_err++; $display("FAIL multi_block_ctr got %h want 00000003", o_ctr);
    end
  endtask

  task automatic test_backpressure();
    key = rand_key(); nonce = {$urandom, $urandom, $urandom};
    run_msg(20, $urandom, 1, 0, 6, 0);
  endtask

  task automatic test_start_while_busy();
    key = rand_key(); nonce = {$urandom, $urandom, $urandom};
    run_msg(20, $urandom, 1, 0, -1, 1);
  endtask

  task automatic test_ctr_overflow();
    key = rand_key(); nonce = {$urandom, $urandom, $urandom};
`ifdef CHACHA_CTR_OVF_ERR_EN
    run_msg(16, 32'hffffffff, 0, 0, -1, 0);
    n_cmp++;
    if (err_a !== 1'b1 || o_ctr !== 32'hffffffff) begin
      n_err++; $display("FAIL ovf_err got err=%b ctr=%h want 1/ffffffff", err_a, o_ctr);
    end
    run_msg(3, $urandom, 1, 0, -1, 0);
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_err++; $display("FAIL ovf_err_clear got %b want 0", err_a);
    end
`else
    run_msg(17, 32'hffffffff, 1, 0, -1, 0);
    n_cmp++;
    if (o_ctr !== 32'h00000000) begin
      n_err++; $display("FAIL ovf_wrap_ctr got %h want 00000000", o_ctr);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    key = rand_key(); nonce = {$urandom, $urandom, $urandom};
    @(posedge clk); #1; start = 1'b1; ctr_init = $urandom | 32'h1;
    @(posedge clk); #1; start = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_err++; $display("FAIL gen_busy got %b want 1", o_busy);
    end
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if ({o_busy, o_rdy, o_dv, o_dout, o_done, o_ctr} !== '0) begin
      n_err++; $display("FAIL gen_reset got %h want 0", {o_busy, o_rdy, o_dv, o_dout, o_done, o_ctr});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    start = 1'b1; ctr_init = $urandom | 32'h1; din_valid = 1'b1; din = $urandom;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_cmp++;
    if (o_dv !== 1'b1) begin
      n_err++; $display("FAIL stream_active got dv=%b want 1", o_dv);
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({o_busy, o_rdy, o_dv, o_dout, o_done, o_ctr} !== '0) begin
      n_err++; $display("FAIL stream_reset got %h want 0", {o_busy, o_rdy, o_dv, o_dout, o_done, o_ctr});
    end
    din_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        n_err++; $display("FAIL post_reset_idle cyc=%0d got done=%b busy=%b", i, o_done, o_busy);
      end
    end
    key = rand_key();
    run_msg(18, $urandom, 1, 0, -1, 0);
  endtask

  task automatic test_core_wait();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; sel = 1'b1;
    key = rand_key(); nonce = {$urandom, $urandom, $urandom};
    run_msg(20, $urandom, 1, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_rfc_vector();
    test_multi_block();
    test_backpressure();
    test_start_while_busy();
    test_ctr_overflow();
    test_reset_midflight();
    test_core_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
